// File: rtl/clk_gen.sv
// Counter/toggle clock divider: out_clk = in_clk / (2*HALF), 50% duty,
// HALF = MAIN_CLK_HZ / (2*CLK_HZ) clamped to at least 1.
// Optional single-cycle rising-edge strobe out_tick when CLKGEN_TICK_EN is defined.
module clk_gen #(
  parameter int unsigned MAIN_CLK_HZ = 50_000_000,
  parameter int unsigned CLK_HZ      = 10_000,
  parameter bit          CLK_INIT    = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
`ifdef CLKGEN_TICK_EN
  output logic out_tick,
`endif
  output logic out_clk
);

  // Guard the division so a bad configuration reaches the elaboration error below.
  localparam int unsigned HALF_RAW = (CLK_HZ == 0) ? 1 : MAIN_CLK_HZ / (2 * CLK_HZ);
  localparam int unsigned HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;
  localparam int unsigned CW       = $clog2(HALF) + 1;
  localparam logic [CW-1:0] LAST   = CW'(HALF - 1);

  generate
    if (CLK_HZ == 0 || MAIN_CLK_HZ == 0) begin : g_bad_cfg
      $error("clk_gen: MAIN_CLK_HZ and CLK_HZ must both be non-zero");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          r_clk;
  logic          w_wrap;

  assign w_wrap  = (r_cnt == LAST);
  assign out_clk = r_clk;

  // Half-period counter: wraps to zero on the last cycle of each half-period.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output level register: toggles when the half-period counter wraps.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_clk <= CLK_INIT;
    end else if (w_wrap) begin
      r_clk <= ~r_clk;
    end
  end

`ifdef CLKGEN_TICK_EN
  logic r_tick;

  assign out_tick = r_tick;

  // Strobe registered alongside the 0->1 transition of out_clk, so it is
  // high exactly during the first in_clk cycle of the high phase.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap & ~r_clk;
    end
  end
`endif

endmodule

// File: tb/tb_clk_gen.sv
// Bench for clk_gen: four parameterisations driven from one clock/reset.
module tb_clk_gen;

  localparam int HA = 5;    // 100 / (2*10)
  localparam int HB = 5;
  localparam int HC = 1;    // 100 / 120 -> 0, clamped
  localparam int HD = 325;  // 50e6 / 153600

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic oc_a, oc_b, oc_c, oc_d;
`ifdef CLKGEN_TICK_EN
  logic tk_a, tk_b, tk_c, tk_d;
`endif

  int nchk = 0;
  int nfail = 0;
  int n = 0;  // rising edges seen since the last reset release

  always #5 clk = ~clk;

  clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(10), .CLK_INIT(1'b0)) u_a (
    .in_clk(clk), .in_rst(rst),
`ifdef CLKGEN_TICK_EN
    .out_tick(tk_a),
`endif
    .out_clk(oc_a));
  clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(10), .CLK_INIT(1'b1)) u_b (
    .in_clk(clk), .in_rst(rst),
`ifdef CLKGEN_TICK_EN
    .out_tick(tk_b),
`endif
    .out_clk(oc_b));
  clk_gen #(.MAIN_CLK_HZ(100), .CLK_HZ(60), .CLK_INIT(1'b0)) u_c (
    .in_clk(clk), .in_rst(rst),
`ifdef CLKGEN_TICK_EN
    .out_tick(tk_c),
`endif
    .out_clk(oc_c));
  clk_gen #(.MAIN_CLK_HZ(50_000_000), .CLK_HZ(76_800), .CLK_INIT(1'b0)) u_d (
    .in_clk(clk), .in_rst(rst),
`ifdef CLKGEN_TICK_EN
    .out_tick(tk_d),
`endif
    .out_clk(oc_d));

  // Reference edge count: the divider state is a pure function of it.
  always @(posedge clk or negedge rst) begin
    if (!rst) n = 0;
    else      n = n + 1;
  end

  function automatic logic lvl(input int edges, input int half, input logic init);
    return init ^ (((edges / half) % 2) != 0);
  endfunction

  function automatic logic tick(input int edges, input int half, input logic init);
    return (edges > 0) && ((edges % half) == 0) && (lvl(edges, half, init) == 1'b1);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b (edges=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic check_all();
    if (!rst) begin
      chk("rst_a", oc_a, 1'b0);
      chk("rst_b", oc_b, 1'b1);
      chk("rst_c", oc_c, 1'b0);
      chk("rst_d", oc_d, 1'b0);
    end else begin
      chk("mdl_a", oc_a, lvl(n, HA, 1'b0));
      chk("mdl_b", oc_b, lvl(n, HB, 1'b1));
      chk("mdl_c", oc_c, lvl(n, HC, 1'b0));
      chk("mdl_d", oc_d, lvl(n, HD, 1'b0));
    end
`ifdef CLKGEN_TICK_EN
    chk("tick_a", tk_a, rst && tick(n, HA, 1'b0));
    chk("tick_b", tk_b, rst && tick(n, HB, 1'b1));
    chk("tick_c", tk_c, rst && tick(n, HC, 1'b0));
    chk("tick_d", tk_d, rst && tick(n, HD, 1'b0));
`endif
  endtask

  typedef struct {
    int   k;      // edges after release
    logic ea, eb, ec, ed;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{5,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{9,  1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{10, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{11, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{14, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{15, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{20, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values, including while the clock runs.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all();

    // Table: levels at fixed edge counts after release.
    rst = 1'b1;
    begin
      int cur;
      cur = 0;
      for (int i = 0; i < 11; i++) begin
        repeat (tbl[i].k - cur) @(negedge clk);
        cur = tbl[i].k;
        chk("tbl_a", oc_a, tbl[i].ea);
        chk("tbl_b", oc_b, tbl[i].eb);
        chk("tbl_c", oc_c, tbl[i].ec);
        chk("tbl_d", oc_d, tbl[i].ed);
`ifdef CLKGEN_TICK_EN
        chk("tbl_tick_a", tk_a, (tbl[i].k == 5) || (tbl[i].k == 15));
`endif
      end
    end

    // Mid-period reset: A is high with 2 edges into its high half (edge 7).
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_pre_a", oc_a, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_async_a", oc_a, 1'b0);
    chk("mid_async_b", oc_b, 1'b1);
    @(negedge clk);
    chk("mid_hold_a", oc_a, 1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      chk("mid_restart_a", oc_a, (e == 5));
    end

    // Period measurement on D across four full periods.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    begin
      int   rises[$];
      int   edges;
      logic prev;
      edges = 0;
      prev = oc_d;
      while (rises.size() < 5 && edges < 4000) begin
        @(posedge clk);
        #1;
        edges++;
        if (oc_d && !prev) rises.push_back(edges);
        prev = oc_d;
      end
      if (rises.size() < 5) begin
        nchk++;
        nfail++;
        $display("FAIL d_timeout: saw %0d rises, required 5 within 4000 edges", rises.size());
      end else begin
        nchk++;
        if (rises[0] != HD) begin
          nfail++;
          $display("FAIL d_first_rise: got edge %0d required %0d", rises[0], HD);
        end
        nchk++;
        if (rises[4] - rises[0] != 4 * 2 * HD) begin
          nfail++;
          $display("FAIL d_4periods: got %0d cycles required %0d", rises[4] - rises[0], 8 * HD);
        end
      end
    end

    // Randomized reset pulses, every cycle checked against the edge-count model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check_all();
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 check_all();
        repeat ($urandom_range(1, 3)) @(negedge clk);
        check_all();
        #2 rst = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
